// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// Optional macro MC_CONTROL_BNE_EN adds the BNE_EX state.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEM_WB   = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    BEQ_EX   = 4'd8,
    ADDI_EX  = 4'd9,
    ADDI_WB  = 4'd10,
`ifdef MC_CONTROL_BNE_EN
    J_EX     = 4'd11,
    BNE_EX   = 4'd12
`else
    J_EX     = 4'd11
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd5;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// R-type funct decoder: maps funct to an ALU operation and flags
// unsupported funct codes (which fall back to add).
module alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       illegal_funct
);

  // Translate funct into the ALU select; unknown codes behave as add
  always_comb begin
    alu_control   = ALU_ADD;
    illegal_funct = 1'b0;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      default: illegal_funct = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit: Moore FSM stepping one instruction phase
// per clock and driving ALU select plus all datapath enables.
// Optional macro MC_CONTROL_BNE_EN enables the bne instruction.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int ALUCTL_W = 3,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_src,
  output logic                pc_en,
  output logic                ior_d,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                illegal,
  output logic [STATE_W-1:0]  state_q
);

  state_t     state_d;
  logic       illegal_q, illegal_d;
  logic [2:0] rtype_alu;
  logic       rtype_bad;
  logic [2:0] alu_sel;
  logic       pc_write, branch, branch_cond;
  logic       mem_write_c, ir_write_c, reg_write_c;

  alu_decoder u_alu_decoder (
    .funct         (funct),
    .alu_control   (rtype_alu),
    .illegal_funct (rtype_bad)
  );

  // Moore output decode; write enables are masked while reset is held
  always_comb begin
    alu_sel     = ALU_ADD;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_B;
    pc_src      = PCSRC_ALU;
    ior_d       = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    branch_cond = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    case (state_t'(state_q))
      FETCH: begin
        alu_src_b  = SRCB_FOUR;
        ir_write_c = 1'b1;
        pc_write   = 1'b1;
      end
      DECODE:   alu_src_b = SRCB_IMM_SH;
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEMRD:    ior_d = 1'b1;
      MEM_WB: begin
        mem_to_reg  = 1'b1;
        reg_write_c = 1'b1;
      end
      MEMWR: begin
        ior_d       = 1'b1;
        mem_write_c = 1'b1;
      end
      RTYPE_EX: begin
        alu_src_a = 1'b1;
        alu_sel   = rtype_alu;
      end
      RTYPE_WB: begin
        reg_dst     = 1'b1;
        reg_write_c = 1'b1;
      end
      BEQ_EX: begin
        alu_src_a   = 1'b1;
        alu_sel     = ALU_SUB;
        pc_src      = PCSRC_ALUOUT;
        branch      = 1'b1;
        branch_cond = zero;
      end
`ifdef MC_CONTROL_BNE_EN
      BNE_EX: begin
        alu_src_a   = 1'b1;
        alu_sel     = ALU_SUB;
        pc_src      = PCSRC_ALUOUT;
        branch      = 1'b1;
        branch_cond = ~zero;
      end
`endif
      ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ADDI_WB:  reg_write_c = 1'b1;
      J_EX: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_control = ALUCTL_W'(alu_sel);
  assign pc_en       = rst_n & (pc_write | (branch & branch_cond));
  assign ir_write    = rst_n & ir_write_c;
  assign mem_write   = rst_n & mem_write_c;
  assign reg_write   = rst_n & reg_write_c;
  assign illegal     = illegal_q;

  // Next-state selection and sticky illegal-instruction tracking
  always_comb begin
    state_d   = FETCH;
    illegal_d = illegal_q;
    case (state_t'(state_q))
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPE_EX;
          OP_BEQ:       state_d = BEQ_EX;
          OP_ADDI:      state_d = ADDI_EX;
          OP_J:         state_d = J_EX;
`ifdef MC_CONTROL_BNE_EN
          OP_BNE:       state_d = BNE_EX;
`endif
          default: begin
            state_d   = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR:   state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    state_d = MEM_WB;
      RTYPE_EX: begin
        state_d = RTYPE_WB;
        if (rtype_bad) illegal_d = 1'b1;
      end
      ADDI_EX:  state_d = ADDI_WB;
      default:  state_d = FETCH;
    endcase
  end

  // State and illegal flag registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= STATE_W'(FETCH);
      illegal_q <= 1'b0;
    end else begin
      state_q   <= STATE_W'(state_d);
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized self-checking bench for mc_control_fsm. Each instruction is
// expanded into its expected per-cycle phase list from the ISA-level
// description of the control unit and compared cycle by cycle.
// Honors MC_CONTROL_BNE_EN to match the build of the design.
module tb_mc_control_fsm;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero;
  logic [2:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic       pc_en, ior_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal;
  logic [3:0] state_q;

  int checks   = 0;
  int failures = 0;
  bit illExp   = 1'b0;

  typedef struct packed {
    state_t     st;
    logic [2:0] alu;
    logic       a;
    logic [1:0] b;
    logic [1:0] ps;
    logic       pcen, iord, mw, irw, rd, m2r, rw, ill;
  } step_t;

  step_t plan[$];

  mc_control_fsm #(.ALUCTL_W(3), .STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .pc_en(pc_en), .ior_d(ior_d), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .illegal(illegal), .state_q(state_q)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports every check
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [14:0] packStep(step_t s);
    return {s.alu, s.a, s.b, s.ps, s.pcen, s.iord, s.mw, s.irw, s.rd, s.m2r, s.rw};
  endfunction

  function automatic step_t blank(state_t s, bit ill);
    step_t x;
    x     = '0;
    x.st  = s;
    x.ill = ill;
    return x;
  endfunction

  function automatic bit opLegal(logic [5:0] op);
    bit ok;
    ok = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) || (op == OP_BEQ) ||
         (op == OP_ADDI) || (op == OP_J);
`ifdef MC_CONTROL_BNE_EN
    ok = ok || (op == OP_BNE);
`endif
    return ok;
  endfunction

  // ISA table for R-type operations: add/sub/and/or/slt -> 0/1/2/3/5
  function automatic logic [2:0] aluFor(logic [5:0] f, output bit bad);
    bad = 1'b0;
    case (f)
      6'b100000: return 3'd0;
      6'b100010: return 3'd1;
      6'b100100: return 3'd2;
      6'b100101: return 3'd3;
      6'b101010: return 3'd5;
      default: begin bad = 1'b1; return 3'd0; end
    endcase
  endfunction

  // Expand one instruction into the phases it must walk through
  task automatic buildPlan(input logic [5:0] op, input logic [5:0] fn, input logic z);
    step_t s;
    bit    ill = illExp;
    bit    bad;
    plan.delete();
    s = blank(FETCH, ill);  s.b = 2'd1; s.irw = 1; s.pcen = 1; plan.push_back(s);
    s = blank(DECODE, ill); s.b = 2'd3; plan.push_back(s);
    if (!opLegal(op)) begin
      ill = 1'b1;
    end else if (op == OP_LW || op == OP_SW) begin
      s = blank(MEMADR, ill); s.a = 1; s.b = 2'd2; plan.push_back(s);
      if (op == OP_LW) begin
        s = blank(MEMRD, ill);  s.iord = 1; plan.push_back(s);
        s = blank(MEM_WB, ill); s.m2r = 1; s.rw = 1; plan.push_back(s);
      end else begin
        s = blank(MEMWR, ill);  s.iord = 1; s.mw = 1; plan.push_back(s);
      end
    end else if (op == OP_RTYPE) begin
      s = blank(RTYPE_EX, ill); s.a = 1; s.alu = aluFor(fn, bad); plan.push_back(s);
      if (bad) ill = 1'b1;
      s = blank(RTYPE_WB, ill); s.rd = 1; s.rw = 1; plan.push_back(s);
    end else if (op == OP_BEQ) begin
      s = blank(BEQ_EX, ill); s.a = 1; s.alu = 3'd1; s.ps = 2'd1; s.pcen = z; plan.push_back(s);
`ifdef MC_CONTROL_BNE_EN
    end else if (op == OP_BNE) begin
      s = blank(BNE_EX, ill); s.a = 1; s.alu = 3'd1; s.ps = 2'd1; s.pcen = ~z; plan.push_back(s);
`endif
    end else if (op == OP_ADDI) begin
      s = blank(ADDI_EX, ill); s.a = 1; s.b = 2'd2; plan.push_back(s);
      s = blank(ADDI_WB, ill); s.rw = 1; plan.push_back(s);
    end else begin
      s = blank(J_EX, ill); s.ps = 2'd2; s.pcen = 1; plan.push_back(s);
    end
    illExp = ill;
  endtask

  // Hold reset for three cycles and confirm the quiescent FETCH view
  task automatic applyReset();
    step_t r;
    r = blank(FETCH, 1'b0); r.b = 2'd1;
    rst_n  = 1'b0;
    illExp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_state", 32'(state_q), 32'(r.st));
      checkOutput("rst_ctrl", 32'({alu_control, alu_src_a, alu_src_b, pc_src, pc_en, ior_d,
                  mem_write, ir_write, reg_dst, mem_to_reg, reg_write}), 32'(packStep(r)));
      checkOutput("rst_illegal", 32'(illegal), 32'd0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  // Run one instruction, optionally cutting it short with a reset
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z, input bit mayAbort);
    int n;
    buildPlan(op, fn, z);
    n = plan.size();
    if (mayAbort) n = $urandom_range(1, plan.size() - 1);
    opcode = op; funct = fn; zero = z;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("state", 32'(state_q), 32'(plan[i].st));
      checkOutput("ctrl", 32'({alu_control, alu_src_a, alu_src_b, pc_src, pc_en, ior_d,
                  mem_write, ir_write, reg_dst, mem_to_reg, reg_write}), 32'(packStep(plan[i])));
      checkOutput("illegal", 32'(illegal), 32'(plan[i].ill));
      @(posedge clk); #1;
    end
    if (mayAbort) applyReset();
  endtask

  initial begin
    logic [5:0] legalFn [5];
    logic [5:0] op, fn;
    legalFn = '{FN_SLT, FN_ADD, FN_SUB, FN_AND, FN_OR};
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
    #1;
    applyReset();

    $display("[TB] directed instructions");
    applyStimulus(OP_LW, 6'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(OP_RTYPE, legalFn[i], 1'($urandom), 1'b0);
    applyStimulus(OP_BEQ, 6'($urandom), 1'b1, 1'b0);
    applyStimulus(OP_BEQ, 6'($urandom), 1'b0, 1'b0);
    applyStimulus(OP_SW, 6'($urandom), 1'b1, 1'b0);
    applyStimulus(OP_J, 6'($urandom), 1'b0, 1'b0);
    applyStimulus(OP_BNE, 6'($urandom), 1'b0, 1'b0);
    applyStimulus(OP_BNE, 6'($urandom), 1'b1, 1'b0);
    applyReset();
    applyStimulus(6'b111111, 6'($urandom), 1'b0, 1'b0);
    applyStimulus(OP_ADDI, 6'($urandom), 1'b0, 1'b0);
    applyStimulus(OP_RTYPE, 6'b000111, 1'b0, 1'b0);
    applyReset();
    applyStimulus(OP_RTYPE, 6'b111111, 1'b0, 1'b0);
    applyStimulus(OP_ADDI, 6'($urandom), 1'b1, 1'b0);

    $display("[TB] random instructions");
    for (int k = 0; k < 300; k++) begin
      fn = legalFn[$urandom_range(0, 4)];
      case ($urandom_range(0, 9))
        0:       op = OP_LW;
        1:       op = OP_SW;
        2, 3: begin
          op = OP_RTYPE;
          if ($urandom_range(0, 5) == 0) fn = 6'($urandom);
        end
        4:       op = OP_BEQ;
        5:       op = OP_BNE;
        6:       op = OP_ADDI;
        7:       op = OP_J;
        default: begin
          op = 6'($urandom);
          for (int t = 0; t < 64 && opLegal(op); t++) op = 6'($urandom);
        end
      endcase
      applyStimulus(op, fn, 1'($urandom), $urandom_range(0, 15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle MIPS control unit that drives the ALU's 3-bit operation select and every datapath enable, one instruction step per clock.
- Sits directly upstream of the ALU.
  - Decodes opcode/funct from the instruction register.
  - Consumes the ALU `zero` flag for branches.
- Supports lw, sw, R-type (add/sub/and/or/slt), beq, addi and j.

Parameters:
- ALUCTL_W, 3, width of the ALU operation-select output.
- STATE_W, 4, width of the state register and debug state output.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  6  instr[31:26] from instruction register.
- funct  input  6  instr[5:0] from instruction register.
- zero  input  1  ALU zero flag (A==B).
- alu_control  output  ALUCTL_W  ALU op: 0 add, 1 sub, 2 and, 3 or, 5 slt.
- alu_src_a  output  1  0 = PC, 1 = register A.
- alu_src_b  output  2  0 = B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2.
- pc_src  output  2  0 = ALU result, 1 = ALUOut register, 2 = jump target.
- pc_en  output  1  PC write enable (pc_write | branch&cond).
- ior_d  output  1  memory address: 0 = PC, 1 = ALUOut.
- mem_write  output  1  data memory write enable.
- ir_write  output  1  instruction register load.
- reg_dst  output  1  0 = rt, 1 = rd.
- mem_to_reg  output  1  0 = ALUOut, 1 = memory data.
- reg_write  output  1  register file write enable.
- illegal  output  1  sticky unsupported-opcode/funct flag.
- state_q  output  STATE_W  current state, debug.

Behaviour:
- Moore FSM. Outputs are combinational from `state_q`, except `pc_en`, which also uses `zero`.
- Reset (`rst_n` low, asynchronous):
  - state = FETCH, `illegal` = 0.
  - While `rst_n` is low, all write enables are forced to 0: `pc_en`, `ir_write`, `mem_write`, `reg_write`.
  - Mux selects and `alu_control` show FETCH values.
  - Reset mid-instruction abandons the instruction; first post-reset edge performs FETCH.
- Unlisted outputs are 0 in each state below.
- States, outputs and transitions:
  - FETCH: `ior_d`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_control`=0, `pc_src`=0, `ir_write`=1, `pc_write`=1 -> DECODE.
  - DECODE: `alu_src_a`=0, `alu_src_b`=3, `alu_control`=0 (branch target precompute). Next state by opcode:
    - 100011/101011 -> MEMADR
    - 000000 -> RTYPE_EX
    - 000100 -> BEQ_EX
    - 001000 -> ADDI_EX
    - 000010 -> J_EX
    - other -> FETCH, set `illegal`.
  - MEMADR: `alu_src_a`=1, `alu_src_b`=2, `alu_control`=0 -> MEMRD if lw, MEMWR if sw.
  - MEMRD: `ior_d`=1 -> MEM_WB.
  - MEM_WB: `reg_dst`=0, `mem_to_reg`=1, `reg_write`=1 -> FETCH.
  - MEMWR: `ior_d`=1, `mem_write`=1 -> FETCH.
  - RTYPE_EX: `alu_src_a`=1, `alu_src_b`=0, `alu_control` from funct:
    - 100000 -> 0
    - 100010 -> 1
    - 100100 -> 2
    - 100101 -> 3
    - 101010 -> 5
    - other -> 0, and set `illegal`.
    - Next: RTYPE_WB.
  - RTYPE_WB: `reg_dst`=1, `mem_to_reg`=0, `reg_write`=1 -> FETCH. Writes even after illegal funct; software-visible result is add.
  - BEQ_EX: `alu_src_a`=1, `alu_src_b`=0, `alu_control`=1, `pc_src`=1, branch=1; `pc_en` = `zero` -> FETCH.
  - ADDI_EX: `alu_src_a`=1, `alu_src_b`=2, `alu_control`=0 -> ADDI_WB.
  - ADDI_WB: `reg_dst`=0, `mem_to_reg`=0, `reg_write`=1 -> FETCH.
  - J_EX: `pc_src`=2, `pc_write`=1 -> FETCH.
- CPI: lw 5; sw, R-type, addi 4; beq, j 3.
- `illegal` is sticky until reset. An illegal opcode costs 2 cycles.
- Encoding 4 (and 6/7) is never driven on `alu_control`.
- Unreachable state encodings -> FETCH next cycle, all enables 0.

Optional Feature:
- Macro `MC_CONTROL_BNE_EN`.
- Defined:
  - Opcode 000101 in DECODE -> BNE_EX.
  - BNE_EX outputs match BEQ_EX, but `pc_en` = ~`zero`.
  - 3-cycle CPI.
- Undefined: 000101 is illegal (-> FETCH, `illegal` set); no BNE_EX state exists.

Decomposition:
- Shared package `mc_pkg`:
  - state enum;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J);
  - funct constants;
  - ALU op constants (ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_SLT=5);
  - ALUSrcB and PCSrc select constants.
- One natural sub-module, `alu_decoder`: combinational funct -> `alu_control` + illegal-funct. Instantiated inside, used only in RTYPE_EX.

Test Plan:
- Reset: hold `rst_n`=0 for 3 cycles at random state -> `state_q`=FETCH, `pc_en`=`ir_write`=`mem_write`=`reg_write`=0, `illegal`=0; first edge after release -> DECODE.
- lw (opcode 100011) -> states FETCH, DECODE, MEMADR, MEMRD, MEM_WB; `reg_write`=1 with `mem_to_reg`=1 only in cycle 5.
- R-type funct 101010 -> `alu_control`=5 in RTYPE_EX, `reg_dst`=1 in RTYPE_WB; repeat for 100000/100010/100100/100101 -> 0/1/2/3.
- beq with `zero`=1 -> `pc_en`=1, `pc_src`=1 in BEQ_EX; with `zero`=0 -> `pc_en`=0; back to FETCH either way.
- opcode 111111 -> FETCH after DECODE, `illegal`=1 and stays 1 across subsequent addi (001000: 4 cycles, `reg_write` in cycle 4).
- With `MC_CONTROL_BNE_EN`: opcode 000101, `zero`=0 -> `pc_en`=1; `zero`=1 -> `pc_en`=0. Without the macro -> `illegal`=1.
